// File: rtl/writeback_stage_if.sv
// =====================================================================
// writeback_stage_if : bundle input, register-file write and counter bus
// Revision: 1.0
// =====================================================================
`default_nettype none

interface writeback_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic              in_slot_v0;
  logic              in_slot_v1;
  logic              in_wen0;
  logic              in_wen1;
  logic [REG_AW-1:0] in_rd0;
  logic [REG_AW-1:0] in_rd1;
  logic              in_load0;
  logic              in_load1;
  logic [DATA_W-1:0] in_alu0;
  logic [DATA_W-1:0] in_alu1;
  logic [DATA_W-1:0] in_mem0;
  logic [DATA_W-1:0] in_mem1;
  logic              wb_hold;
  logic              wbEn0;
  logic              wbEn1;
  logic [REG_AW-1:0] addrWb0;
  logic [REG_AW-1:0] addrWb1;
  logic [DATA_W-1:0] dataWb0;
  logic [DATA_W-1:0] dataWb1;
  logic [31:0]       retired;
  logic [15:0]       waw_drops;

  // Surrounding pipeline and register file
  modport master (
    output in_valid, in_slot_v0, in_slot_v1, in_wen0, in_wen1,
           in_rd0, in_rd1, in_load0, in_load1,
           in_alu0, in_alu1, in_mem0, in_mem1, wb_hold,
    input  in_ready, wbEn0, wbEn1, addrWb0, addrWb1,
           dataWb0, dataWb1, retired, waw_drops
  );

  // The writeback stage itself
  modport slave (
    input  in_valid, in_slot_v0, in_slot_v1, in_wen0, in_wen1,
           in_rd0, in_rd1, in_load0, in_load1,
           in_alu0, in_alu1, in_mem0, in_mem1, wb_hold,
    output in_ready, wbEn0, wbEn1, addrWb0, addrWb1,
           dataWb0, dataWb1, retired, waw_drops
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
// =====================================================================
// writeback_stage : two-slot writeback with output register + skid buffer
// Revision: 1.0
// =====================================================================
`default_nettype none

module writeback_stage #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int ZERO_REG = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  writeback_stage_if.slave  bus
);

  typedef struct packed {
    logic              v0;
    logic              wen0;
    logic [REG_AW-1:0] rd0;
    logic [DATA_W-1:0] data0;
    logic              v1;
    logic              wen1;
    logic [REG_AW-1:0] rd1;
    logic [DATA_W-1:0] data1;
  } bundle_t;

  bundle_t     out_q, out_d;
  bundle_t     skid_q, skid_d;
  bundle_t     in_bundle;
  logic        out_v_q, out_v_d;
  logic        skid_v_q, skid_v_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] retired_q, retired_d;
  logic [15:0] waw_q, waw_d;

  logic accept;
  logic advance;
  logic write_cycle;
  logic rd0_zero;
  logic rd1_zero;
  logic we0_raw;
  logic we1_raw;
  logic waw_hit;

  // Load/ALU selection is resolved at capture so OUT/SKID hold final data
  always_comb begin
    in_bundle.v0    = bus.in_slot_v0;
    in_bundle.wen0  = bus.in_wen0;
    in_bundle.rd0   = bus.in_rd0;
    in_bundle.data0 = bus.in_load0 ? bus.in_mem0 : bus.in_alu0;
    in_bundle.v1    = bus.in_slot_v1;
    in_bundle.wen1  = bus.in_wen1;
    in_bundle.rd1   = bus.in_rd1;
    in_bundle.data1 = bus.in_load1 ? bus.in_mem1 : bus.in_alu1;
  end

  assign accept      = bus.in_valid & in_ready_q;
  assign advance     = ~out_v_q | ~bus.wb_hold;
  assign write_cycle = out_v_q & ~bus.wb_hold;

  assign rd0_zero = (ZERO_REG != 0) && (out_q.rd0 == '0);
  assign rd1_zero = (ZERO_REG != 0) && (out_q.rd1 == '0);
  assign we0_raw  = write_cycle & out_q.v0 & out_q.wen0 & ~rd0_zero;
  assign we1_raw  = write_cycle & out_q.v1 & out_q.wen1 & ~rd1_zero;
  assign waw_hit  = we0_raw & we1_raw & (out_q.rd0 == out_q.rd1);

  // Enables are gated by rst so a bundle caught by reset never writes
  assign bus.wbEn0     = rst & we0_raw & ~waw_hit;
  assign bus.wbEn1     = rst & we1_raw;
  assign bus.addrWb0   = out_v_q ? out_q.rd0   : '0;
  assign bus.addrWb1   = out_v_q ? out_q.rd1   : '0;
  assign bus.dataWb0   = out_v_q ? out_q.data0 : '0;
  assign bus.dataWb1   = out_v_q ? out_q.data1 : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.retired   = retired_q;
  assign bus.waw_drops = waw_q;

  always_comb begin
    out_v_d   = out_v_q;
    out_d     = out_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    retired_d = retired_q;
    waw_d     = waw_q;

    if (advance) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = accept;
        if (accept) begin
          skid_d = in_bundle;
        end
      end else begin
        out_v_d = accept;
        if (accept) begin
          out_d = in_bundle;
        end
      end
    end else if (accept) begin
      skid_v_d = 1'b1;
      skid_d   = in_bundle;
    end

    if (write_cycle) begin
      retired_d = retired_q + 32'(out_q.v0) + 32'(out_q.v1);
    end
    if (waw_hit && (waw_q != 16'hFFFF)) begin
      waw_d = waw_q + 16'd1;
    end

    in_ready_d = ~skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_v_q    <= 1'b0;
      out_q      <= '0;
      skid_v_q   <= 1'b0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      retired_q  <= '0;
      waw_q      <= '0;
    end else begin
      out_v_q    <= out_v_d;
      out_q      <= out_d;
      skid_v_q   <= skid_v_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      retired_q  <= retired_d;
      waw_q      <= waw_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// =====================================================================
// tb_writeback_stage : queue-model bench for writeback_stage
// Revision: 1.0
// =====================================================================
`default_nettype none

module tb_writeback_stage;

  typedef struct packed {
    logic        v0, wen0, ld0;
    logic [3:0]  rd0;
    logic [15:0] alu0, mem0;
    logic        v1, wen1, ld1;
    logic [3:0]  rd1;
    logic [15:0] alu1, mem1;
  } stim_t;

  typedef struct {
    logic        v0, wen0;
    logic [3:0]  rd0;
    logic [15:0] d0;
    logic        v1, wen1;
    logic [3:0]  rd1;
    logic [15:0] d1;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  logic  hold;
  logic  check_en;
  stim_t cur;

  int n_cmp  = 0;
  int n_fail = 0;

  writeback_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

  assign bus.in_valid   = in_valid;
  assign bus.wb_hold    = hold;
  assign bus.in_slot_v0 = cur.v0;
  assign bus.in_wen0    = cur.wen0;
  assign bus.in_load0   = cur.ld0;
  assign bus.in_rd0     = cur.rd0;
  assign bus.in_alu0    = cur.alu0;
  assign bus.in_mem0    = cur.mem0;
  assign bus.in_slot_v1 = cur.v1;
  assign bus.in_wen1    = cur.wen1;
  assign bus.in_load1   = cur.ld1;
  assign bus.in_rd1     = cur.rd1;
  assign bus.in_alu1    = cur.alu1;
  assign bus.in_mem1    = cur.mem1;

  writeback_stage #(.DATA_W(16), .REG_AW(4), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic exp_t to_exp(input stim_t s);
    exp_t e;
    e.v0 = s.v0; e.wen0 = s.wen0; e.rd0 = s.rd0; e.d0 = s.ld0 ? s.mem0 : s.alu0;
    e.v1 = s.v1; e.wen1 = s.wen1; e.rd1 = s.rd1; e.d1 = s.ld1 ? s.mem1 : s.alu1;
    return e;
  endfunction

  function automatic logic wants_write(input logic v, input logic wen, input logic [3:0] rd);
    return v && wen && (rd != 4'd0);
  endfunction

  // Behavioural model: the stage is a FIFO of at most two accepted bundles
  exp_t        q[$];
  logic        m_rdy = 1'b0;
  logic [31:0] m_ret = '0;
  logic [15:0] m_waw = '0;

  always @(posedge clk) begin
    exp_t f;
    if (!rst) begin
      q.delete();
      m_ret = '0;
      m_waw = '0;
      m_rdy = 1'b0;
    end else begin
      if (q.size() > 0 && !hold) begin
        f = q.pop_front();
        m_ret = m_ret + 32'(f.v0) + 32'(f.v1);
        if (wants_write(f.v0, f.wen0, f.rd0) && wants_write(f.v1, f.wen1, f.rd1) &&
            f.rd0 == f.rd1 && m_waw != 16'hFFFF)
          m_waw = m_waw + 16'd1;
      end
      if (in_valid && m_rdy) q.push_back(to_exp(cur));
      m_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    exp_t        f;
    logic        e0, e1;
    logic [3:0]  a0, a1;
    logic [15:0] d0, d1;
    if (check_en) begin
      e0 = 1'b0; e1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      if (q.size() > 0) begin
        f  = q[0];
        a0 = f.rd0; a1 = f.rd1; d0 = f.d0; d1 = f.d1;
        if (rst && !hold) begin
          e1 = wants_write(f.v1, f.wen1, f.rd1);
          e0 = wants_write(f.v0, f.wen0, f.rd0) && !(e1 && f.rd0 == f.rd1);
        end
      end
      chk("wbEn0",     32'(bus.wbEn0),     32'(e0));
      chk("wbEn1",     32'(bus.wbEn1),     32'(e1));
      chk("addrWb0",   32'(bus.addrWb0),   32'(a0));
      chk("addrWb1",   32'(bus.addrWb1),   32'(a1));
      chk("dataWb0",   32'(bus.dataWb0),   32'(d0));
      chk("dataWb1",   32'(bus.dataWb1),   32'(d1));
      chk("in_ready",  32'(bus.in_ready),  32'(m_rdy));
      chk("retired",   bus.retired,        m_ret);
      chk("waw_drops", 32'(bus.waw_drops), 32'(m_waw));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; hold = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("lit_ready_after_reset", 32'(bus.in_ready), 32'd1);
    chk("lit_retired_after_reset", bus.retired, 32'd0);
  endtask

  function automatic stim_t mk(input logic v0, input logic w0, input logic l0, input logic [3:0] r0,
                               input logic [15:0] x0, input logic v1, input logic w1, input logic l1,
                               input logic [3:0] r1, input logic [15:0] x1);
    stim_t s;
    s.v0 = v0; s.wen0 = w0; s.ld0 = l0; s.rd0 = r0;
    s.alu0 = l0 ? 16'h5A5A : x0; s.mem0 = l0 ? x0 : 16'hA5A5;
    s.v1 = v1; s.wen1 = w1; s.ld1 = l1; s.rd1 = r1;
    s.alu1 = l1 ? 16'h5A5A : x1; s.mem1 = l1 ? x1 : 16'hA5A5;
    return s;
  endfunction

  initial begin
    rst = 1'b0; in_valid = 1'b0; hold = 1'b0; check_en = 1'b0; cur = '0;
    step(); step();
    check_en = 1'b1;
    @(negedge clk);
    chk("lit_reset_ready", 32'(bus.in_ready), 32'd0);
    chk("lit_reset_wbEn0", 32'(bus.wbEn0), 32'd0);

    // Single bundle: ALU write to R3, load write to R5
    do_reset();
    step();
    cur = mk(1, 1, 0, 4'd3, 16'h1234, 1, 1, 1, 4'd5, 16'hBEEF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_single_wbEn0", 32'(bus.wbEn0), 32'd1);
    chk("lit_single_addr0", 32'(bus.addrWb0), 32'd3);
    chk("lit_single_data0", 32'(bus.dataWb0), 32'h1234);
    chk("lit_single_wbEn1", 32'(bus.wbEn1), 32'd1);
    chk("lit_single_addr1", 32'(bus.addrWb1), 32'd5);
    chk("lit_single_data1", 32'(bus.dataWb1), 32'hBEEF);
    step();
    @(negedge clk);
    chk("lit_single_retired", bus.retired, 32'd2);

    // WAW on R7: younger slot wins
    do_reset();
    step();
    cur = mk(1, 1, 0, 4'd7, 16'h0001, 1, 1, 0, 4'd7, 16'h0002);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_waw_wbEn0", 32'(bus.wbEn0), 32'd0);
    chk("lit_waw_wbEn1", 32'(bus.wbEn1), 32'd1);
    chk("lit_waw_data1", 32'(bus.dataWb1), 32'h0002);
    step();
    @(negedge clk);
    chk("lit_waw_drops", 32'(bus.waw_drops), 32'd1);
    chk("lit_waw_retired", bus.retired, 32'd2);

    // R0 write dropped, bubble in slot 1
    do_reset();
    step();
    cur = mk(1, 1, 0, 4'd0, 16'h7777, 0, 1, 0, 4'd9, 16'h8888);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_r0_wbEn0", 32'(bus.wbEn0), 32'd0);
    chk("lit_r0_wbEn1", 32'(bus.wbEn1), 32'd0);
    step();
    @(negedge clk);
    chk("lit_r0_retired", bus.retired, 32'd1);

    // Back-pressure: three hold cycles with continuous valid
    do_reset();
    step();
    hold = 1'b1; in_valid = 1'b1;
    cur = mk(1, 1, 0, 4'd1, 16'hAAAA, 1, 1, 0, 4'd2, 16'hAAAB);
    step();
    cur = mk(1, 1, 0, 4'd3, 16'hBBBB, 1, 1, 0, 4'd4, 16'hBBBC);
    step();
    @(negedge clk);
    chk("lit_bp_ready_low", 32'(bus.in_ready), 32'd0);
    chk("lit_bp_hold_wbEn0", 32'(bus.wbEn0), 32'd0);
    cur = mk(1, 1, 0, 4'd5, 16'hCCCC, 1, 1, 0, 4'd6, 16'hCCCD);
    step();
    hold = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("lit_bp_first_addr0", 32'(bus.addrWb0), 32'd1);
    chk("lit_bp_first_wbEn0", 32'(bus.wbEn0), 32'd1);
    step();
    @(negedge clk);
    chk("lit_bp_second_addr0", 32'(bus.addrWb0), 32'd3);
    chk("lit_bp_second_data1", 32'(bus.dataWb1), 32'hBBBC);
    step();
    @(negedge clk);
    chk("lit_bp_retired", bus.retired, 32'd4);

    // Reset with OUT and SKID both full
    do_reset();
    step();
    hold = 1'b1; in_valid = 1'b1;
    cur = mk(1, 1, 0, 4'd8, 16'h1111, 1, 1, 0, 4'd9, 16'h2222);
    step();
    cur = mk(1, 1, 0, 4'd10, 16'h3333, 1, 1, 0, 4'd11, 16'h4444);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_rst_full_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0; hold = 1'b0;
    @(negedge clk);
    chk("lit_rst_during_wbEn0", 32'(bus.wbEn0), 32'd0);
    chk("lit_rst_during_wbEn1", 32'(bus.wbEn1), 32'd0);
    step();
    @(negedge clk);
    chk("lit_rst_ready_low", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("lit_rst_ready_back", 32'(bus.in_ready), 32'd1);
    chk("lit_rst_after_wbEn1", 32'(bus.wbEn1), 32'd0);
    chk("lit_rst_retired", bus.retired, 32'd0);
    chk("lit_rst_waw", 32'(bus.waw_drops), 32'd0);

    // Randomized traffic with small register range to provoke WAW and R0
    for (int i = 0; i < 3000; i++) begin
      cur.v0   = 1'($urandom_range(0, 3) != 0);
      cur.wen0 = 1'($urandom_range(0, 3) != 0);
      cur.ld0  = 1'($urandom_range(0, 1));
      cur.rd0  = 4'($urandom_range(0, 3));
      cur.alu0 = 16'($urandom);
      cur.mem0 = 16'($urandom);
      cur.v1   = 1'($urandom_range(0, 3) != 0);
      cur.wen1 = 1'($urandom_range(0, 3) != 0);
      cur.ld1  = 1'($urandom_range(0, 1));
      cur.rd1  = 4'($urandom_range(0, 3));
      cur.alu1 = 16'($urandom);
      cur.mem1 = 16'($urandom);
      in_valid = 1'($urandom_range(0, 9) < 7);
      hold     = 1'($urandom_range(0, 9) < 3);
      rst      = 1'($urandom_range(0, 299) != 0);
      step();
    end

    rst = 1'b1; in_valid = 1'b0; hold = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
